// File: rtl/alu_issue.sv
// Issue/writeback sequencer for ARMv4 data-processing ops driving an external ALU.
// Define ALU_ISSUE_IMM_EN to decode I=1 rotated immediates; otherwise they are rejected.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  input  logic [31:0] rf_rdata_a,
  input  logic [31:0] rf_rdata_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [63:0] alu_out,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [3:0]  flags,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, ERR} state_t;

  state_t      state, next;
  logic [31:0] ir, opa, opb, res, opb_next;
  logic        accept, reject, imm_rej;

  wire [3:0] rn = ir[19:16];
  wire [3:0] rd = ir[15:12];
  wire [3:0] rm = ir[3:0];
  wire [3:0] op = ir[24:21];
  wire       s  = ir[20];

  wire [3:0] in_op = instr[24:21];

`ifdef ALU_ISSUE_IMM_EN
  logic [4:0]  rot;
  logic [31:0] imm;
  assign imm_rej  = 1'b0;
  assign rot      = {ir[11:8], 1'b0};
  assign imm      = ({24'h0, ir[7:0]} >> rot) | ({24'h0, ir[7:0]} << (6'd32 - {1'b0, rot}));
  assign opb_next = ir[25] ? imm : rf_rdata_b;
`else
  assign imm_rej  = instr[25];
  assign opb_next = rf_rdata_b;
`endif

  assign accept = instr_valid && instr_ready;
  assign reject = (instr[27:26] != 2'b00) || (in_op == 4'b0101) || (in_op == 4'b0110) ||
                  (in_op == 4'b0111) || (!instr[25] && (instr[11:4] != 8'h00)) || imm_rej;

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (accept) next = reject ? ERR : READ;
      READ:    next = EXEC;
      EXEC:    next = WB;
      WB:      next = IDLE;
      ERR:     next = IDLE;
      default: next = IDLE;
    endcase
  end

  // TST/TEQ/CMP/CMN share opcode[3:2]=10: compare-only, always set flags
  wire cmp_op = (op[3:2] == 2'b10);
  wire upd    = s || cmp_op;

  logic [32:0] sum;
  logic [31:0] diff, rdiff;
  logic [3:0]  nflags;

  always_comb begin
    sum    = {1'b0, opa} + {1'b0, opb};
    diff   = opa - opb;
    rdiff  = opb - opa;
    nflags = {res[31], (res == 32'h0), flags[1], flags[0]};
    case (op)
      4'b0100, 4'b1011: begin
        nflags[1] = sum[32];
        nflags[0] = (opa[31] == opb[31]) && (sum[31] != opa[31]);
      end
      4'b0010, 4'b1010: begin
        nflags[1] = (opa >= opb);
        nflags[0] = (opa[31] != opb[31]) && (diff[31] != opa[31]);
      end
      4'b0011: begin
        nflags[1] = (opb >= opa);
        nflags[0] = (opa[31] != opb[31]) && (rdiff[31] != opb[31]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_ready <= 1'b0;
      ir          <= '0;
      opa         <= '0;
      opb         <= '0;
      res         <= '0;
      flags       <= '0;
    end else begin
      state       <= next;
      instr_ready <= (next == IDLE);
      if (accept)                ir    <= instr;
      if (state == READ) begin
        opa <= rf_rdata_a;
        opb <= opb_next;
      end
      if (state == EXEC)         res   <= alu_out[31:0];
      if ((state == WB) && upd)  flags <= nflags;
    end
  end

  always_comb begin
    rf_raddr_a = '0;
    rf_raddr_b = '0;
    if (state == READ) begin
      rf_raddr_a = rn;
      rf_raddr_b = rm;
    end
  end

  // ADD/CMN reuse the subtractor with a negated B; MOV/MVN zero A into OR/NOR
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    if (state == EXEC) begin
      alu_a = opa;
      alu_b = opb;
      case (op)
        4'b0000, 4'b1000: alu_sel = 4'b0000;
        4'b1110: begin alu_sel = 4'b0000; alu_b = ~opb; end
        4'b0001, 4'b1001: alu_sel = 4'b0001;
        4'b0010, 4'b1010: alu_sel = 4'b0010;
        4'b0011: alu_sel = 4'b0011;
        4'b0100, 4'b1011: begin alu_sel = 4'b0010; alu_b = -opb; end
        4'b1100: alu_sel = 4'b1001;
        4'b1101: begin alu_sel = 4'b1001; alu_a = '0; end
        4'b1111: begin alu_sel = 4'b1011; alu_a = '0; end
        default: alu_sel = 4'b0000;
      endcase
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (state == WB && !cmp_op) begin
      rf_we    = 1'b1;
      rf_waddr = rd;
      rf_wdata = res;
    end
  end

  assign err = (state == ERR);

  logic unused;
  assign unused = ^{alu_out[63:32], ir[31:25], ir[11:4]};

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: bench-owned register file and ALU, vector table, random model, reset corner.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [3:0]  rf_raddr_a, rf_raddr_b;
  logic [31:0] rf_rdata_a, rf_rdata_b;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic [63:0] alu_out;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  flags;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [16];
  logic [3:0]  mflags;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_out(alu_out), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .flags(flags), .err(err)
  );

  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  // Datapath ALU: 0 AND, 1 XOR, 2 A-B, 3 B-A, 9 OR, 11 NOR; upper half is junk
  always_comb begin
    logic [31:0] lo;
    lo = 32'hBAD0BAD0;
    case (alu_sel)
      4'b0000: lo = alu_a & alu_b;
      4'b0001: lo = alu_a ^ alu_b;
      4'b0010: lo = alu_a - alu_b;
      4'b0011: lo = alu_b - alu_a;
      4'b1001: lo = alu_a | alu_b;
      4'b1011: lo = ~(alu_a | alu_b);
      default: lo = 32'hBAD0BAD0;
    endcase
    alu_out = {32'hDEADBEEF, lo};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run(input logic [31:0] ins, input logic ewe, input logic [3:0] ewa,
                     input logic [31:0] ewd, input logic eerr, input logic [3:0] efl,
                     input string tag);
    int n;
    logic [3:0] wev, errv, rdyv;
    logic [3:0] wa;
    logic [31:0] wd;
    logic alu_dirty;
    n = 0; wa = '0; wd = '0; alu_dirty = 1'b0;
    wev = '0; errv = '0; rdyv = '0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    if (!instr_ready) begin
      chk({tag, "_ready_timeout"}, {31'h0, instr_ready}, 32'h1);
      return;
    end
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    instr = $urandom;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wev[k]  = rf_we;
      errv[k] = err;
      rdyv[k] = instr_ready;
      if (k != 1 && ((alu_a | alu_b) != 0 || alu_sel != 0)) alu_dirty = 1'b1;
      if (rf_we) begin
        wa = rf_waddr;
        wd = rf_wdata;
        rf[rf_waddr] = rf_wdata;
      end
    end
    chk({tag, "_we"},    {28'h0, wev},  ewe  ? 32'h4 : 32'h0);
    chk({tag, "_err"},   {28'h0, errv}, eerr ? 32'h1 : 32'h0);
    chk({tag, "_ready"}, {28'h0, rdyv}, eerr ? 32'hE : 32'h8);
    chk({tag, "_flags"}, {28'h0, flags}, {28'h0, efl});
    chk({tag, "_alu_idle"}, {31'h0, alu_dirty}, 32'h0);
    if (ewe) begin
      chk({tag, "_waddr"}, {28'h0, wa}, {28'h0, ewa});
      chk({tag, "_wdata"}, wd, ewd);
    end
  endtask

  typedef struct {
    logic [31:0] r0, r1, ins;
    logic        ewe;
    logic [3:0]  ewa;
    logic [31:0] ewd;
    logic        eerr;
    logic [3:0]  efl;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [31:0] ror32(input logic [31:0] x, input int r);
    if (r == 0) return x;
    return (x >> r) | (x << (32 - r));
  endfunction

  function automatic logic signed_ovf(input longint v);
    return (v > 64'sd2147483647) || (v < -64'sd2147483648);
  endfunction

  task automatic rand_one(input int idx);
    logic [31:0] ins, a, b, r;
    logic [3:0] op, rn, rd, rm, fl;
    logic s, i, rej, c, v, upd, wr;
    logic [1:0] top;
    logic [7:0] sh;
    longint sa, sb;
    op = 4'($urandom_range(0, 15));
    s  = 1'($urandom);
    i  = ($urandom_range(0, 3) == 0);
    rn = 4'($urandom); rd = 4'($urandom); rm = 4'($urandom);
    top = ($urandom_range(0, 9) == 0) ? 2'b01 : 2'b00;
    sh  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    ins = i ? {4'hE, top, 1'b1, op, s, rn, rd, 12'($urandom)}
            : {4'hE, top, 1'b0, op, s, rn, rd, sh, rm};
    rej = (top != 0) || (op >= 5 && op <= 7) || (!i && sh != 0);
`ifndef ALU_ISSUE_IMM_EN
    rej = rej || i;
`endif
    a = rf[rn];
    b = i ? ror32({24'h0, ins[7:0]}, 2 * int'(ins[11:8])) : rf[rm];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = mflags[1]; v = mflags[0]; r = '0;
    case (op)
      0, 8:  r = a & b;
      1, 9:  r = a ^ b;
      2, 10: begin r = a - b; c = (a >= b); v = signed_ovf(sa - sb); end
      3:     begin r = b - a; c = (b >= a); v = signed_ovf(sb - sa); end
      4, 11: begin
        r = a + b;
        c = ((64'(a) + 64'(b)) >> 32) != 0;
        v = signed_ovf(sa + sb);
      end
      12: r = a | b;
      13: r = b;
      14: r = a & ~b;
      15: r = ~b;
      default: r = '0;
    endcase
    upd = s || (op >= 8 && op <= 11);
    wr  = !(op >= 8 && op <= 11);
    fl  = (upd && !rej) ? {r[31], r == 0, c, v} : mflags;
    run(ins, wr && !rej, rd, r, rej, fl, $sformatf("rnd%0d", idx));
    mflags = fl;
  endtask

  initial begin
    int wecnt;
    for (int k = 0; k < 16; k++) rf[k] = $urandom;

    tbl[0]  = '{32'h5, 32'h7, 32'hE0902001, 1'b1, 4'd2, 32'd12, 1'b0, 4'b0000};
    tbl[1]  = '{32'h3, 32'h5, 32'hE0502001, 1'b1, 4'd2, 32'hFFFFFFFE, 1'b0, 4'b1000};
    tbl[2]  = '{32'h80000000, 32'h80000000, 32'hE1500001, 1'b0, 4'd0, 32'h0, 1'b0, 4'b0110};
`ifdef ALU_ISSUE_IMM_EN
    tbl[3]  = '{32'h0, 32'h0, 32'hE3A034FF, 1'b1, 4'd3, 32'hFF000000, 1'b0, 4'b0110};
`else
    tbl[3]  = '{32'h0, 32'h0, 32'hE3A034FF, 1'b0, 4'd0, 32'h0, 1'b1, 4'b0110};
`endif
    tbl[4]  = '{32'h5, 32'h7, 32'hE0A02001, 1'b0, 4'd0, 32'h0, 1'b1, 4'b0110};
    tbl[5]  = '{32'h80000000, 32'h1, 32'hE1902001, 1'b1, 4'd2, 32'h80000001, 1'b0, 4'b1010};
    tbl[6]  = '{32'h5, 32'h7, 32'hE0802081, 1'b0, 4'd0, 32'h0, 1'b1, 4'b1010};
    tbl[7]  = '{32'h7FFFFFFF, 32'h1, 32'hE0902001, 1'b1, 4'd2, 32'h80000000, 1'b0, 4'b1001};
    tbl[8]  = '{32'hFFFFFFFF, 32'h1, 32'hE0902001, 1'b1, 4'd2, 32'h0, 1'b0, 4'b0110};
    tbl[9]  = '{32'h3, 32'h5, 32'hE0702001, 1'b1, 4'd2, 32'h2, 1'b0, 4'b0010};
    tbl[10] = '{32'h1234, 32'h0, 32'hE1F02001, 1'b1, 4'd2, 32'hFFFFFFFF, 1'b0, 4'b1010};
    tbl[11] = '{32'h9, 32'h9, 32'hE1100001, 1'b0, 4'd0, 32'h0, 1'b0, 4'b0010};

    // Reset state
    #3;
    chk("rst_ready", {31'h0, instr_ready}, 32'h0);
    chk("rst_we",    {31'h0, rf_we}, 32'h0);
    chk("rst_err",   {31'h0, err}, 32'h0);
    chk("rst_flags", {28'h0, flags}, 32'h0);
    chk("rst_alu",   alu_a | alu_b | {28'h0, alu_sel}, 32'h0);
    chk("rst_wbus",  rf_wdata | {28'h0, rf_waddr}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_ready_low", {31'h0, instr_ready}, 32'h0);
    @(posedge clk);
    #1 chk("rel_ready_high", {31'h0, instr_ready}, 32'h1);
    @(negedge clk);

    for (int t = 0; t < 12; t++) begin
      rf[0] = tbl[t].r0;
      rf[1] = tbl[t].r1;
      run(tbl[t].ins, tbl[t].ewe, tbl[t].ewa, tbl[t].ewd, tbl[t].eerr, tbl[t].efl,
          $sformatf("vec%0d", t));
    end

    mflags = 4'b0010;
    for (int t = 0; t < 60; t++) rand_one(t);

    // Reset asserted in the middle of EXEC drops the instruction
    rf[0] = 32'h5; rf[1] = 32'h7;
    wecnt = 0;
    while (!instr_ready) @(negedge clk);
    instr = 32'hE0902001;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", {28'h0, flags}, 32'h0);
    chk("mid_rst_ready", {31'h0, instr_ready}, 32'h0);
    chk("mid_rst_alu",   alu_a | alu_b | {28'h0, alu_sel}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rf_we) wecnt++;
    end
    rst_n = 1'b1;
    #1 chk("mid_rel_ready_low", {31'h0, instr_ready}, 32'h0);
    @(posedge clk);
    #1 chk("mid_rel_ready_high", {31'h0, instr_ready}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rf_we) wecnt++;
    end
    chk("mid_rst_no_we", wecnt, 32'h0);
    chk("mid_rst_flags_after", {28'h0, flags}, 32'h0);

    run(32'hE0902001, 1'b1, 4'd2, 32'd12, 1'b0, 4'b0000, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
